// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the MixColumns datapath.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam int         NUM_COLS = 4;

    typedef logic [7:0]  byte_t;
    typedef byte_t [0:3] column_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mix_state_t;

    // MSB position of byte idx within the 128-bit state (byte 0 sits at the top).
    function automatic int byte_msb(input int idx);
        return 127 - 8 * idx;
    endfunction

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_column_unit.sv
// Combinational single-column InvMixColumns; with INV_MIX_FWD_EN defined a fwd_i
// input additionally selects forward MixColumns.
module inv_mix_column_unit
    import aes_pkg::*;
(
    input  column_t col_i,
`ifdef INV_MIX_FWD_EN
    input  logic    fwd_i,
`endif
    output column_t col_o
);

    byte_t      x2  [4];
    byte_t      x4  [4];
    byte_t      x8  [4];
    byte_t      m9  [4];
    byte_t      m11 [4];
    byte_t      m13 [4];
    byte_t      m14 [4];
    byte_t      inv_b;
    byte_t      fwd_b;
    logic [1:0] r0, r1, r2, r3;

    always_comb begin
        col_o = '0;
        inv_b = '0;
        fwd_b = '0;
        r0    = '0;
        r1    = '0;
        r2    = '0;
        r3    = '0;
        for (int r = 0; r < 4; r++) begin
            r0     = 2'(r);
            x2[r0]  = xtime(col_i[r0]);
            x4[r0]  = xtime(x2[r0]);
            x8[r0]  = xtime(x4[r0]);
            m9[r0]  = x8[r0] ^ col_i[r0];
            m11[r0] = x8[r0] ^ x2[r0] ^ col_i[r0];
            m13[r0] = x8[r0] ^ x4[r0] ^ col_i[r0];
            m14[r0] = x8[r0] ^ x4[r0] ^ x2[r0];
        end
        // Each output row uses the same coefficient row, rotated by its index.
        for (int r = 0; r < 4; r++) begin
            r0    = 2'(r);
            r1    = r0 + 2'd1;
            r2    = r0 + 2'd2;
            r3    = r0 + 2'd3;
            inv_b = m14[r0] ^ m11[r1] ^ m13[r2] ^ m9[r3];
            fwd_b = x2[r0] ^ x2[r1] ^ col_i[r1] ^ col_i[r2] ^ col_i[r3];
`ifdef INV_MIX_FWD_EN
            col_o[r0] = fwd_i ? fwd_b : inv_b;
`else
            col_o[r0] = inv_b;
`endif
        end
    end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns engine, COLS_PER_CYCLE columns per busy cycle.
// Optional INV_MIX_FWD_EN adds a fwd port selecting forward MixColumns per state.
module inv_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
`ifdef INV_MIX_FWD_EN
    input  logic         fwd,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    // state | meaning
    // IDLE  | in_ready high, waiting for an input state
    // BUSY  | transforming columns cnt_q.. each edge
    // DONE  | out_valid high, result held until out_ready
    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
            $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] CNT_LAST = 2'(NUM_COLS - COLS_PER_CYCLE);

    mix_state_t   fsm_q;
    logic [1:0]   cnt_q;
    logic [127:0] state_q;
    logic [127:0] state_d;
    logic         in_ready_q;
    logic         out_valid_q;
`ifdef INV_MIX_FWD_EN
    logic         fwd_q;
`endif

    logic [1:0] col_idx [COLS_PER_CYCLE];
    column_t    col_in  [COLS_PER_CYCLE];
    column_t    col_out [COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_idx[g] = cnt_q + 2'(g);
        assign col_in[g]  = state_q[byte_msb(4 * int'(col_idx[g])) -: 32];

        inv_mix_column_unit u_col (
            .col_i (col_in[g]),
`ifdef INV_MIX_FWD_EN
            .fwd_i (fwd_q),
`endif
            .col_o (col_out[g])
        );
    end

    always_comb begin
        state_d = state_q;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            state_d[byte_msb(4 * int'(col_idx[j])) -: 32] = col_out[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            cnt_q       <= '0;
            state_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef INV_MIX_FWD_EN
            fwd_q       <= 1'b0;
`endif
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        state_q    <= in_data;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        fsm_q      <= ST_BUSY;
`ifdef INV_MIX_FWD_EN
                        fwd_q      <= fwd;
`endif
                    end
                end
                ST_BUSY: begin
                    state_q <= state_d;
                    cnt_q   <= cnt_q + CNT_STEP;
                    if (cnt_q == CNT_LAST) begin
                        fsm_q       <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        fsm_q       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    fsm_q       <= ST_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = state_q;

endmodule
